pwm_carrier_sync_ctrl: RTL

//  Configuration and sequencing controller for NCH carrier generators (PKG_pwm domain).

---
 rtl/pwm_carrier_sync_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/pwm_carrier_sync_ctrl.sv
// pwm_carrier_sync_ctrl
//  Per-channel shadow configuration (period, init_carr, count_mode) with
//  glitch-free release to the active outputs at each channel's mask_event.
//  All channels start in the same cycle; each stops at its own next mask_event.
//  count_mode is carried as an opaque MW-bit field per channel, and pwm_onoff
//  is one bit per channel (1 = PWM_ON, 0 = PWM_OFF).
module pwm_carrier_sync_ctrl #(
  parameter int NCH = 4,
  parameter int CW  = 16,
  parameter int MW  = 2,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_wr,
  input  logic [CHW-1:0]      cfg_ch,
  input  logic [CW-1:0]       cfg_period,
  input  logic [CW-1:0]       cfg_init,
  input  logic [MW-1:0]       cfg_mode,
  input  logic                start,
  input  logic                stop,
  input  logic                update_req,
  input  logic                update_imm,
  input  logic [NCH-1:0]      mask_event,
  output logic [NCH*CW-1:0]   period,
  output logic [NCH*CW-1:0]   init_carr,
  output logic [NCH*MW-1:0]   count_mode,
  output logic [NCH-1:0]      pwm_onoff,
  output logic                busy,
  output logic                update_done
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, STOPPING} state_t;

  state_t         state, state_n;
  logic [NCH-1:0] dirty, dirty_n;
  logic [NCH-1:0] pend, pend_n;
  logic [NCH-1:0] onoff, onoff_n;
  logic           done_n;
  logic [NCH-1:0] wr_mask;
  logic [NCH-1:0] load_mask;
  logic [NCH-1:0] clr_dirty;
  logic [NCH-1:0] pnew;

  logic [CW-1:0]  shd_period [NCH];
  logic [CW-1:0]  shd_init   [NCH];
  logic [MW-1:0]  shd_mode   [NCH];
  logic [CW-1:0]  act_period [NCH];
  logic [CW-1:0]  act_init   [NCH];
  logic [MW-1:0]  act_mode   [NCH];

  // Next-state, load/clear masks and done pulse for the sequencing FSM
  always_comb begin
    state_n   = state;
    pend_n    = pend;
    onoff_n   = onoff;
    done_n    = 1'b0;
    wr_mask   = '0;
    load_mask = '0;
    clr_dirty = '0;
    pnew      = '0;
    // Out-of-range channel numbers never match and are dropped here.
    for (int i = 0; i < NCH; i++) begin
      if (cfg_wr && (int'(cfg_ch) == i)) wr_mask[i] = 1'b1;
    end
    case (state)
      IDLE: begin
        // A simultaneous stop suppresses start.
        if (start && !stop) begin
          load_mask = '1;
          clr_dirty = '1;
          state_n   = ARM;
        end
      end
      ARM: begin
        onoff_n = '1;
        state_n = RUN;
      end
      RUN: begin
        if (stop) begin
          // Outstanding scheduled loads are abandoned silently.
          pend_n  = '0;
          state_n = STOPPING;
        end else if (update_imm) begin
          load_mask = dirty;
          clr_dirty = dirty;
          pend_n    = '0;
          done_n    = 1'b1;
        end else begin
          pnew      = pend | (update_req ? dirty : '0);
          load_mask = pnew & mask_event;
          clr_dirty = load_mask;
          pend_n    = pnew & ~load_mask;
          // Fires when the last scheduled load lands, or at once for an empty request.
          done_n    = ((pend != '0) || update_req) && (pend_n == '0);
        end
      end
      STOPPING: begin
        // A zero-period channel never produces mask_event, so release it directly.
        for (int i = 0; i < NCH; i++) begin
          if (mask_event[i] || (act_period[i] == '0)) onoff_n[i] = 1'b0;
        end
        if (onoff_n == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // A write coinciding with a load keeps the channel dirty for the new value.
    dirty_n = (dirty & ~clr_dirty) | wr_mask;
  end

  // Control state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      dirty       <= '0;
      pend        <= '0;
      onoff       <= '0;
      update_done <= 1'b0;
    end else begin
      state       <= state_n;
      dirty       <= dirty_n;
      pend        <= pend_n;
      onoff       <= onoff_n;
      update_done <= done_n;
    end
  end

  // Shadow capture and shadow-to-active release; loads read the pre-write shadow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        shd_period[i] <= '0;
        shd_init[i]   <= '0;
        shd_mode[i]   <= '0;
        act_period[i] <= '0;
        act_init[i]   <= '0;
        act_mode[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_mask[i]) begin
          shd_period[i] <= cfg_period;
          shd_init[i]   <= cfg_init;
          shd_mode[i]   <= cfg_mode;
        end
        if (load_mask[i]) begin
          act_period[i] <= shd_period[i];
          act_init[i]   <= shd_init[i];
          act_mode[i]   <= shd_mode[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_pack
    assign period[g*CW +: CW]     = act_period[g];
    assign init_carr[g*CW +: CW]  = act_init[g];
    assign count_mode[g*MW +: MW] = act_mode[g];
  end

  assign pwm_onoff = onoff;
  assign busy      = (state != IDLE);

endmodule
